// File: rtl/tone_sequencer_pkg.sv
// Shared types and constants for the tone sequencer: FSM states and the packed pattern entry layout.
package tone_sequencer_pkg;

    localparam int PERIOD_W = 12;
    localparam int DUR_W    = 4;

    localparam logic [DUR_W-1:0]    END_DUR     = '0;
    localparam logic [PERIOD_W-1:0] REST_PERIOD = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [PERIOD_W-1:0] period;
        logic [DUR_W-1:0]    dur;
    } entry_t;

endpackage

// File: rtl/tone_sequencer_if.sv
// Host-side pattern/control port and tonegen-side voice outputs of the sequencer.
interface tone_sequencer_if #(
    parameter int STEPS = 8
) ();
    localparam int AW = $clog2(STEPS);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          start;
    logic          stop;
    logic          loop;
    logic [11:0]   period;
    logic          tone_en;
    logic          busy;
    logic [AW-1:0] step_idx;
    logic          note_strobe;
    logic          done;

    modport master (
        output wr_en, wr_addr, wr_data, start, stop, loop,
        input  period, tone_en, busy, step_idx, note_strobe, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop, loop,
        output period, tone_en, busy, step_idx, note_strobe, done
    );
endinterface

// File: rtl/tone_sequencer_prescaler.sv
// Tempo prescaler: one-cycle tick every TICK_DIV cycles, combinational off the count.
// Latency: tick in the TICK_DIV-th cycle after clr drops; no backpressure, clr holds count at 0.
module tick_prescaler #(
    parameter int TICK_DIV = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = !clr && (cnt == TC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/tone_sequencer.sv
// Steps a stored note pattern onto one tonegen voice; start -> period/tone_en valid 2 cycles later.
// All outputs registered; no backpressure (start ignored while busy, stop aborts from any state).
module tone_sequencer
    import tone_sequencer_pkg::*;
#(
    parameter int STEPS     = 8,
    parameter int TICK_DIV  = 1024,
    parameter int GAP_TICKS = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    tone_sequencer_if.slave bus
);
    localparam int AW = $clog2(STEPS);
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [AW-1:0] LAST_STEP = AW'(STEPS - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TICKS - 1);

    entry_t              pat [STEPS];
    entry_t              cur;
    state_t              state, state_nxt;
    logic [AW-1:0]       step_q, step_nxt;
    logic [PERIOD_W-1:0] period_q, period_nxt;
    logic [DUR_W-1:0]    dur_q, dur_nxt;
    logic [3:0]          tcnt, tcnt_nxt;
    logic [GW-1:0]       gcnt, gcnt_nxt;
    logic                tone_q, tone_nxt;
    logic                strobe_q, strobe_nxt;
    logic                done_q, done_nxt;
    logic                busy_q;
    logic                advance;
    logic                tick;
    logic                presc_clr;

    assign presc_clr = (state != ST_PLAY) && (state != ST_GAP);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (presc_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) pat[i] <= '0;
        end else if (bus.wr_en) begin
            pat[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        state_nxt  = state;
        step_nxt   = step_q;
        period_nxt = period_q;
        dur_nxt    = dur_q;
        tcnt_nxt   = tcnt;
        gcnt_nxt   = gcnt;
        tone_nxt   = tone_q;
        strobe_nxt = 1'b0;
        done_nxt   = 1'b0;
        advance    = 1'b0;
        cur        = pat[step_q];

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = ST_LOAD;
                    step_nxt  = '0;
                end
            end
            ST_LOAD: begin
                if (cur.dur == END_DUR) begin
                    // An end marker at step 0 under loop would spin in LOAD forever; end instead.
                    if (bus.loop && (step_q != '0)) begin
                        step_nxt = '0;
                    end else begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    state_nxt  = ST_PLAY;
                    period_nxt = cur.period;
                    tone_nxt   = (cur.period != REST_PERIOD);
                    strobe_nxt = 1'b1;
                    dur_nxt    = cur.dur;
                    tcnt_nxt   = '0;
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    if (tcnt == (dur_q - 4'd1)) begin
                        tone_nxt = 1'b0;
                        tcnt_nxt = '0;
                        if (GAP_TICKS > 0) begin
                            state_nxt = ST_GAP;
                            gcnt_nxt  = '0;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        tcnt_nxt = tcnt + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (gcnt == GAP_LAST) advance = 1'b1;
                    else                  gcnt_nxt = gcnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (advance) begin
            state_nxt = ST_LOAD;
            if (step_q == LAST_STEP) begin
                if (bus.loop) begin
                    step_nxt = '0;
                end else begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end else begin
                step_nxt = step_q + 1'b1;
            end
        end

        // Abort overrides everything, including a same-cycle start or normal end.
        if (bus.stop) begin
            state_nxt  = ST_IDLE;
            tone_nxt   = 1'b0;
            period_nxt = '0;
            strobe_nxt = 1'b0;
            done_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            step_q   <= '0;
            period_q <= '0;
            dur_q    <= '0;
            tcnt     <= '0;
            gcnt     <= '0;
            tone_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            step_q   <= step_nxt;
            period_q <= period_nxt;
            dur_q    <= dur_nxt;
            tcnt     <= tcnt_nxt;
            gcnt     <= gcnt_nxt;
            tone_q   <= tone_nxt;
            strobe_q <= strobe_nxt;
            done_q   <= done_nxt;
            busy_q   <= (state_nxt != ST_IDLE);
        end
    end

    assign bus.period      = period_q;
    assign bus.tone_en     = tone_q;
    assign bus.busy        = busy_q;
    assign bus.step_idx    = step_q;
    assign bus.note_strobe = strobe_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench: STEPS=4, TICK_DIV=4; dut0 with GAP_TICKS=1, dut1 with GAP_TICKS=0 (legato).
module tb_tone_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    tone_sequencer_if #(.STEPS(4)) bus0 ();
    tone_sequencer_if #(.STEPS(4)) bus1 ();

    tone_sequencer #(.STEPS(4), .TICK_DIV(4), .GAP_TICKS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    tone_sequencer #(.STEPS(4), .TICK_DIV(4), .GAP_TICKS(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    always #5 clk = ~clk;

    logic        cap_tone [48];
    logic [11:0] cap_per  [48];
    logic        cap_stb  [48];
    logic        cap_done [48];
    logic        cap_busy [48];
    logic [1:0]  cap_step [48];
    int          cnt_tone, cnt_stb, cnt_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr0(input int a, input logic [11:0] p, input logic [3:0] d);
        bus0.wr_en = 1'b1; bus0.wr_addr = 2'(a); bus0.wr_data = {p, d};
        @(negedge clk);
        bus0.wr_en = 1'b0;
    endtask

    task automatic wr1(input int a, input logic [11:0] p, input logic [3:0] d);
        bus1.wr_en = 1'b1; bus1.wr_addr = 2'(a); bus1.wr_data = {p, d};
        @(negedge clk);
        bus1.wr_en = 1'b0;
    endtask

    // Returns at "sample 0": the negedge after the edge that accepted start (state LOAD).
    task automatic start0();
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
    endtask

    task automatic stop0();
        bus0.stop = 1'b1;
        @(negedge clk);
        bus0.stop = 1'b0;
    endtask

    task automatic capture(input int n);
        cnt_tone = 0; cnt_stb = 0; cnt_done = 0;
        for (int k = 0; k < n; k++) begin
            cap_tone[k] = bus0.tone_en;
            cap_per[k]  = bus0.period;
            cap_stb[k]  = bus0.note_strobe;
            cap_done[k] = bus0.done;
            cap_busy[k] = bus0.busy;
            cap_step[k] = bus0.step_idx;
            cnt_tone += int'(bus0.tone_en);
            cnt_stb  += int'(bus0.note_strobe);
            cnt_done += int'(bus0.done);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bus0.wr_en = 0; bus0.wr_addr = 0; bus0.wr_data = 0;
        bus0.start = 0; bus0.stop = 0; bus0.loop = 0;
        bus1.wr_en = 0; bus1.wr_addr = 0; bus1.wr_data = 0;
        bus1.start = 0; bus1.stop = 0; bus1.loop = 0;
        adv(3);
        chk("rst_tone", bus0.tone_en, 0);
        chk("rst_period", bus0.period, 0);
        chk("rst_busy", bus0.busy, 0);
        chk("rst_step", bus0.step_idx, 0);
        chk("rst_strobe", bus0.note_strobe, 0);
        chk("rst_done", bus0.done, 0);
        rst_n = 1'b1;
        adv(1);

        // 1: single pass with gaps and a rest step
        wr0(0, 12'h100, 2); wr0(1, 12'h080, 1); wr0(2, 12'h000, 1); wr0(3, 12'hfff, 0);
        start0();
        capture(40);
        chk("t1_load_busy", cap_busy[0], 1);
        chk("t1_load_tone", cap_tone[0], 0);
        chk("t1_s0_tone", cap_tone[1], 1);
        chk("t1_s0_period", cap_per[1], 12'h100);
        chk("t1_s0_strobe", cap_stb[1], 1);
        chk("t1_s0_last", cap_tone[8], 1);
        chk("t1_gap_tone", cap_tone[9], 0);
        chk("t1_gap_period", cap_per[9], 12'h100);
        chk("t1_s1_load_step", cap_step[13], 1);
        chk("t1_s1_tone", cap_tone[14], 1);
        chk("t1_s1_period", cap_per[14], 12'h080);
        chk("t1_rest_strobe", cap_stb[23], 1);
        chk("t1_rest_tone", cap_tone[23], 0);
        chk("t1_rest_step", cap_step[23], 2);
        chk("t1_end_step", cap_step[31], 3);
        chk("t1_done", cap_done[32], 1);
        chk("t1_done_busy", cap_busy[32], 0);
        chk("t1_done_pulse", cap_done[33], 0);
        chk("t1_tone_cycles", cnt_tone, 12);
        chk("t1_strobes", cnt_stb, 3);
        chk("t1_done_count", cnt_done, 1);

        // 2: loop on end marker, then stop mid-note
        bus0.loop = 1'b1;
        start0();
        capture(40);
        chk("t2_wrap_load", cap_step[32], 0);
        chk("t2_wrap_busy", cap_busy[32], 1);
        chk("t2_wrap_strobe", cap_stb[33], 1);
        chk("t2_strobes", cnt_stb, 4);
        chk("t2_no_done", cnt_done, 0);
        chk("t2_mid_note", bus0.tone_en, 1);
        stop0();
        chk("t2_stop_tone", bus0.tone_en, 0);
        chk("t2_stop_busy", bus0.busy, 0);
        chk("t2_stop_done", bus0.done, 0);
        chk("t2_stop_period", bus0.period, 0);
        adv(1);
        chk("t2_stop_done2", bus0.done, 0);
        bus0.loop = 1'b0;

        // 3: all four steps dur=1, end at STEPS-1
        wr0(0, 12'h111, 1); wr0(1, 12'h222, 1); wr0(2, 12'h333, 1); wr0(3, 12'h444, 1);
        start0();
        capture(40);
        chk("t3_step0", cap_step[1], 0);
        chk("t3_step1", cap_step[10], 1);
        chk("t3_step2", cap_step[19], 2);
        chk("t3_step3", cap_step[28], 3);
        chk("t3_period3", cap_per[28], 12'h444);
        chk("t3_done", cap_done[36], 1);
        chk("t3_done_busy", cap_busy[36], 0);
        chk("t3_done_count", cnt_done, 1);
        bus0.loop = 1'b1;
        start0();
        capture(40);
        chk("t3_wrap_busy", cap_busy[36], 1);
        chk("t3_wrap_step", cap_step[36], 0);
        chk("t3_wrap_strobe", cap_stb[37], 1);
        chk("t3_wrap_period", cap_per[37], 12'h111);
        chk("t3_wrap_no_done", cnt_done, 0);
        stop0();

        // 5: start while busy ignored; edit playing entry takes effect next pass
        start0();
        adv(11);
        start0();
        chk("t5_no_restart_step", bus0.step_idx, 1);
        chk("t5_no_restart_per", bus0.period, 12'h222);
        wr0(1, 12'h555, 1);
        chk("t5_edit_not_yet", bus0.period, 12'h222);
        adv(33);
        chk("t5_edit_step", bus0.step_idx, 1);
        chk("t5_edit_strobe", bus0.note_strobe, 1);
        chk("t5_edit_heard", bus0.period, 12'h555);
        stop0();
        bus0.loop = 1'b0;
        bus0.start = 1'b1; bus0.stop = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0; bus0.stop = 1'b0;
        chk("t5_startstop_busy", bus0.busy, 0);
        adv(1);
        chk("t5_startstop_busy2", bus0.busy, 0);
        chk("t5_startstop_tone", bus0.tone_en, 0);

        // 4: end marker at step 0 with loop must terminate
        wr0(0, 12'h100, 0);
        bus0.loop = 1'b1;
        start0();
        capture(6);
        chk("t4_load_busy", cap_busy[0], 1);
        chk("t4_done", cap_done[1], 1);
        chk("t4_idle", cap_busy[1], 0);
        chk("t4_stay_idle", cap_busy[2], 0);
        chk("t4_no_tone", cnt_tone, 0);
        bus0.loop = 1'b0;

        // 6: async reset mid-PLAY clears outputs and pattern
        wr0(0, 12'h100, 2);
        start0();
        adv(3);
        chk("t6_pre_tone", bus0.tone_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_tone", bus0.tone_en, 0);
        chk("t6_rst_period", bus0.period, 0);
        chk("t6_rst_busy", bus0.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        adv(1);
        start0();
        capture(4);
        chk("t6_cleared_done", cap_done[1], 1);
        chk("t6_cleared_tone", cnt_tone, 0);

        // 6b: GAP_TICKS=0, notes separated only by LOAD
        wr1(0, 12'h100, 1); wr1(1, 12'h080, 1); wr1(2, 12'h000, 0);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        adv(4);
        chk("t6b_s0_tone", bus1.tone_en, 1);
        adv(1);
        chk("t6b_load_tone", bus1.tone_en, 0);
        chk("t6b_load_step", bus1.step_idx, 1);
        adv(1);
        chk("t6b_s1_tone", bus1.tone_en, 1);
        chk("t6b_s1_period", bus1.period, 12'h080);
        chk("t6b_s1_strobe", bus1.note_strobe, 1);
        adv(5);
        chk("t6b_done", bus1.done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
